// File: rtl/cardinal_nic_if.sv
// Processor-side register bus and router-side link signals of one cardinal_nic.
// slave is the NIC's view; master is the view of the processor/router environment.
interface cardinal_nic_if #(
    parameter int DATA_WIDTH = 64
);
    logic [1:0]            addr;
    logic [0:DATA_WIDTH-1] d_in;
    logic [0:DATA_WIDTH-1] d_out;
    logic                  nicEn;
    logic                  nicWrEn;

    logic                  net_si;
    logic                  net_ri;
    logic [0:DATA_WIDTH-1] net_di;
    logic                  net_so;
    logic                  net_ro;
    logic [0:DATA_WIDTH-1] net_do;
    logic                  net_polarity;

    modport slave (
        input  addr, d_in, nicEn, nicWrEn,
        input  net_si, net_di, net_ro, net_polarity,
        output d_out, net_ri, net_so, net_do
    );

    modport master (
        output addr, d_in, nicEn, nicWrEn,
        output net_si, net_di, net_ro, net_polarity,
        input  d_out, net_ri, net_so, net_do
    );
endinterface

// File: rtl/cardinal_nic.sv
// Network interface card: one-packet output buffer toward the mesh router and
// one-packet input buffer from it, exposed to the processor as four registers.
module cardinal_nic #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                clk,
    input  logic                reset,
    cardinal_nic_if.slave       nic
);
    localparam logic [1:0] ADDR_IN_DATA    = 2'b00;
    localparam logic [1:0] ADDR_IN_STATUS  = 2'b01;
    localparam logic [1:0] ADDR_OUT_DATA   = 2'b10;
    localparam logic [1:0] ADDR_OUT_STATUS = 2'b11;

    logic [0:DATA_WIDTH-1] in_buf;
    logic [0:DATA_WIDTH-1] out_buf;
    logic                  in_full;
    logic                  out_full;
    logic                  net_so_q;
    logic [0:DATA_WIDTH-1] net_do_q;

    logic rd_access;
    logic wr_access;
    logic in_consume;
    logic out_accept;
    logic inject;
    logic eject;

    assign rd_access  = nic.nicEn & ~nic.nicWrEn;
    assign wr_access  = nic.nicEn &  nic.nicWrEn;
    assign in_consume = rd_access & (nic.addr == ADDR_IN_DATA) & in_full;
    assign out_accept = wr_access & (nic.addr == ADDR_OUT_DATA) & ~out_full;

    // A buffered packet leaves only when the router's even/odd phase matches its VC bit.
    assign inject = out_full & nic.net_ro & (nic.net_polarity == out_buf[0]);
    assign eject  = nic.net_si & ~in_full;

    assign nic.net_ri = ~in_full;
    assign nic.net_so = net_so_q;
    assign nic.net_do = net_do_q;

    always_comb begin
        nic.d_out = '0;
        if (rd_access) begin
            case (nic.addr)
                ADDR_IN_DATA:    nic.d_out = in_buf;
                ADDR_IN_STATUS:  nic.d_out = {{(DATA_WIDTH-1){1'b0}}, in_full};
                ADDR_OUT_DATA:   nic.d_out = out_buf;
                ADDR_OUT_STATUS: nic.d_out = {{(DATA_WIDTH-1){1'b0}}, out_full};
                default:         nic.d_out = '0;
            endcase
        end
    end

    // Input channel: arrival and processor consumption never coincide, since
    // the router is held off (net_ri=0) for as long as the buffer is full.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_buf  <= '0;
            in_full <= 1'b0;
        end else if (eject) begin
            in_buf  <= nic.net_di;
            in_full <= 1'b1;
        end else if (in_consume) begin
            in_full <= 1'b0;
        end
    end

    // Output channel: a write is only taken while empty, so it cannot collide with an inject.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_buf  <= '0;
            out_full <= 1'b0;
            net_so_q <= 1'b0;
            net_do_q <= '0;
        end else begin
            net_so_q <= inject;
            if (inject) begin
                net_do_q <= out_buf;
                out_full <= 1'b0;
            end else if (out_accept) begin
                out_buf  <= nic.d_in;
                out_full <= 1'b1;
            end
        end
    end
endmodule
